// File: rtl/seven_seg_scanner.sv
// Multiplexed common-anode seven-segment driver: a load strobe samples a binary value, a serial
// double-dabble engine converts it to BCD, and a prescaled scanner drives one digit at a time.
module seven_seg_scanner #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned BIN_WIDTH  = 14,
  parameter int unsigned SCAN_DIV   = 100000
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic [BIN_WIDTH-1:0]  value,
  input  logic                  load,
  input  logic [NUM_DIGITS-1:0] dp_mask,
  input  logic                  blank_lz,
  input  logic                  enable,
  output logic [NUM_DIGITS-1:0] an,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic                  busy,
  output logic                  overflow
);

  localparam int unsigned BcdW = 4 * NUM_DIGITS;
  localparam int unsigned CntW = (BIN_WIDTH > 1) ? $clog2(BIN_WIDTH) : 1;
  localparam int unsigned PscW = $clog2(SCAN_DIV);
  localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  function automatic logic [31:0] pow10(input int unsigned n);
    logic [31:0] p;
    p = 32'd1;
    for (int unsigned k = 0; k < n; k++) begin
      p = p * 32'd10;
    end
    return p;
  endfunction

  localparam logic [31:0] OvfLimit = pow10(NUM_DIGITS);

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'h7F;
    endcase
  endfunction

  typedef enum logic [1:0] {
    StIdle,
    StConvert,
    StCommit
  } state_e;

  // Converter state
  state_e                r_state, w_state_d;
  logic [BIN_WIDTH-1:0]  r_bin, w_bin_d;
  logic [BcdW-1:0]       r_bcd, w_bcd_d;
  logic [BcdW-1:0]       w_bcd_adj;
  logic [CntW-1:0]       r_cnt, w_cnt_d;
  logic                  r_ovf_cap, w_ovf_cap_d;
  logic                  r_pend_vld, w_pend_vld_d;
  logic [BIN_WIDTH-1:0]  r_pend_val, w_pend_val_d;
  logic [BcdW-1:0]       r_disp, w_disp_d;
  logic                  r_overflow, w_overflow_d;
  logic [BIN_WIDTH-1:0]  w_start_val;
  logic [31:0]           w_start_ext;

  // Scanner state
  logic [PscW-1:0]       r_presc, w_presc_d;
  logic [IdxW-1:0]       r_idx, w_idx_d;
  logic [NUM_DIGITS-1:0] r_an, w_an_d;
  logic [6:0]            r_seg, w_seg_d;
  logic                  r_dp, w_dp_d;
  logic [3:0]            w_digit;
  logic                  w_lz_blank;

  // A strobe arriving in the commit cycle is newer than anything held as pending.
  always_comb begin
    w_start_val = load ? value : r_pend_val;
    w_start_ext = 32'(w_start_val);
  end

  always_comb begin
    w_bcd_adj = r_bcd;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) begin
        w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    w_state_d    = r_state;
    w_bin_d      = r_bin;
    w_bcd_d      = r_bcd;
    w_cnt_d      = r_cnt;
    w_ovf_cap_d  = r_ovf_cap;
    w_pend_vld_d = r_pend_vld;
    w_pend_val_d = r_pend_val;
    w_disp_d     = r_disp;
    w_overflow_d = r_overflow;
    case (r_state)
      StIdle: begin
        if (load) begin
          w_state_d   = StConvert;
          w_bin_d     = value;
          w_bcd_d     = '0;
          w_cnt_d     = '0;
          w_ovf_cap_d = (32'(value) >= OvfLimit);
        end
      end
      StConvert: begin
        if (load) begin
          w_pend_vld_d = 1'b1;
          w_pend_val_d = value;
        end
        w_bcd_d = {w_bcd_adj[BcdW-2:0], r_bin[BIN_WIDTH-1]};
        w_bin_d = r_bin << 1;
        w_cnt_d = r_cnt + 1'b1;
        if (r_cnt == CntW'(BIN_WIDTH - 1)) begin
          w_state_d = StCommit;
        end
      end
      StCommit: begin
        w_disp_d     = r_bcd;
        w_overflow_d = r_ovf_cap;
        if (load || r_pend_vld) begin
          w_state_d    = StConvert;
          w_bin_d      = w_start_val;
          w_bcd_d      = '0;
          w_cnt_d      = '0;
          w_ovf_cap_d  = (w_start_ext >= OvfLimit);
          w_pend_vld_d = 1'b0;
        end else begin
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state    <= StIdle;
      r_bin      <= '0;
      r_bcd      <= '0;
      r_cnt      <= '0;
      r_ovf_cap  <= 1'b0;
      r_pend_vld <= 1'b0;
      r_pend_val <= '0;
      r_disp     <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_bin      <= w_bin_d;
      r_bcd      <= w_bcd_d;
      r_cnt      <= w_cnt_d;
      r_ovf_cap  <= w_ovf_cap_d;
      r_pend_vld <= w_pend_vld_d;
      r_pend_val <= w_pend_val_d;
      r_disp     <= w_disp_d;
      r_overflow <= w_overflow_d;
    end
  end

  always_comb begin
    w_presc_d = r_presc + 1'b1;
    w_idx_d   = r_idx;
    if (r_presc == PscW'(SCAN_DIV - 1)) begin
      w_presc_d = '0;
      w_idx_d   = (r_idx == IdxW'(NUM_DIGITS - 1)) ? '0 : r_idx + 1'b1;
    end
  end

  // Digit i>0 goes dark only when it and every more-significant digit are zero.
  always_comb begin
    w_digit    = r_disp[{r_idx, 2'b00} +: 4];
    w_lz_blank = blank_lz && !r_overflow && (r_idx != '0);
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if ((i >= 32'(r_idx)) && (r_disp[4*i +: 4] != 4'd0)) begin
        w_lz_blank = 1'b0;
      end
    end
  end

  always_comb begin
    w_an_d  = '1;
    w_seg_d = 7'h7F;
    w_dp_d  = 1'b1;
    if (enable && !w_lz_blank) begin
      w_an_d  = ~(NUM_DIGITS'(1) << r_idx);
      w_seg_d = r_overflow ? 7'b0111111 : seg_decode(w_digit);
      w_dp_d  = ~dp_mask[r_idx];
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_presc <= '0;
      r_idx   <= '0;
      r_an    <= '1;
      r_seg   <= 7'h7F;
      r_dp    <= 1'b1;
    end else begin
      r_presc <= w_presc_d;
      r_idx   <= w_idx_d;
      r_an    <= w_an_d;
      r_seg   <= w_seg_d;
      r_dp    <= w_dp_d;
    end
  end

  assign an       = r_an;
  assign seg      = r_seg;
  assign dp       = r_dp;
  assign busy     = (r_state != StIdle);
  assign overflow = r_overflow;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Scoreboard bench for seven_seg_scanner: each load pushes the frame it should produce; a monitor
// follows busy to every commit and compares overflow and a scan window of an/seg/dp.
module tb_seven_seg_scanner;

  localparam int unsigned ND = 4;
  localparam int unsigned BW = 14;
  localparam int unsigned SD = 4;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S6 = 7'b0000010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] S8 = 7'b0000000;
  localparam logic [6:0] S9 = 7'b0010000;
  localparam logic [6:0] SDASH = 7'b0111111;
  localparam logic [6:0] SOFF = 7'h7F;

  logic          CLK = 1'b0;
  logic          RESET_N = 1'b0;
  logic [13:0]   value;
  logic          load;
  logic [3:0]    dp_mask;
  logic          blank_lz;
  logic          enable;
  logic [3:0]    an;
  logic [6:0]    seg;
  logic          dp;
  logic          busy;
  logic          overflow;

  typedef struct packed {
    logic        ovf;
    logic [27:0] segs;
    logic [3:0]  lit;
    logic [3:0]  dpn;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass = 0;
  bit   mon_active = 1'b0;
  int   run_len = 0;
  int   last_run = 0;

  seven_seg_scanner #(
    .NUM_DIGITS(ND),
    .BIN_WIDTH (BW),
    .SCAN_DIV  (SD)
  ) dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .value   (value),
    .load    (load),
    .dp_mask (dp_mask),
    .blank_lz(blank_lz),
    .enable  (enable),
    .an      (an),
    .seg     (seg),
    .dp      (dp),
    .busy    (busy),
    .overflow(overflow)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input bit ok, input string detail);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: %s", name, detail);
  endtask

  task automatic push(input logic ovf, input logic [27:0] segs, input logic [3:0] lit,
                      input logic [3:0] dpn);
    exp_t e;
    e.ovf  = ovf;
    e.segs = segs;
    e.lit  = lit;
    e.dpn  = dpn;
    exp_q.push_back(e);
  endtask

  task automatic load_val(input logic [13:0] v);
    value = v;
    load  = 1'b1;
    @(negedge CLK);
    load  = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || mon_active || busy) && n < 500) begin
      @(negedge CLK);
      n++;
    end
    check({name, " done"}, n < 500, $sformatf("got timeout after %0d cycles, want idle", n));
    @(negedge CLK);
  endtask

  // Length of each uninterrupted busy-high run, sampled on the falling edge.
  always @(negedge CLK) begin
    if (!RESET_N) run_len <= 0;
    else if (busy) run_len <= run_len + 1;
    else if (run_len != 0) begin
      last_run <= run_len;
      run_len  <= 0;
    end
  end

  initial begin : monitor
    exp_t e;
    bit   more;
    bit   chained;
    bit   bad_an;
    bit   bad[4];
    int   seen[4];
    int   found;
    int   win;
    bit   ok;
    forever begin
      @(negedge CLK);
      if (RESET_N && busy) begin
        more = 1'b1;
        for (int i = 0; i < BW + 1; i++) begin
          @(negedge CLK);
          if (!RESET_N) begin
            more = 1'b0;
            break;
          end
        end
        while (more) begin
          check("commit", exp_q.size() != 0, "got a commit, want a queued expected frame");
          if (exp_q.size() != 0) e = exp_q.pop_front();
          else e = '0;
          mon_active = 1'b1;
          check("overflow", overflow === e.ovf, $sformatf("got %b want %b", overflow, e.ovf));
          chained = busy;
          win = chained ? BW : ND * SD;
          bad_an = 1'b0;
          for (int d = 0; d < ND; d++) begin
            bad[d]  = 1'b0;
            seen[d] = 0;
          end
          for (int s = 0; s < win; s++) begin
            @(negedge CLK);
            found = -1;
            for (int d = 0; d < ND; d++) begin
              if (an === ~(4'b0001 << d)) found = d;
            end
            if (found >= 0) begin
              seen[found]++;
              if (seg !== e.segs[found*7 +: 7] || dp !== e.dpn[found]) bad[found] = 1'b1;
            end else if (an !== 4'b1111 || seg !== SOFF || dp !== 1'b1) begin
              bad_an = 1'b1;
            end
          end
          check("dark pins", !bad_an, "got a non-one-hot an or lit seg/dp, want an=1111 seg=7F dp=1");
          for (int d = 0; d < ND; d++) begin
            ok = e.lit[d] ? (!bad[d] && (chained || seen[d] == SD)) : (seen[d] == 0);
            check($sformatf("digit%0d", d), ok,
                  $sformatf("got %0d cycles segerr=%0b, want lit=%b seg=%b dp=%b (%0d cycles)",
                            seen[d], bad[d], e.lit[d], e.segs[d*7 +: 7], e.dpn[d], SD));
          end
          if (chained) @(negedge CLK);
          else begin
            mon_active = 1'b0;
            more = 1'b0;
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no finish, want bench completion");
    $fatal(1);
  end

  initial begin : stim
    logic [3:0] prev;
    logic [3:0] want;
    int         d0;
    int         n;
    bit         ok;
    value    = '0;
    load     = 1'b0;
    dp_mask  = 4'b0000;
    blank_lz = 1'b0;
    enable   = 1'b1;
    repeat (3) @(negedge CLK);
    check("reset an", an === 4'b1111, $sformatf("got %b want 1111", an));
    check("reset seg", seg === SOFF, $sformatf("got %b want 1111111", seg));
    check("reset dp", dp === 1'b1, $sformatf("got %b want 1", dp));
    check("reset busy", busy === 1'b0, $sformatf("got %b want 0", busy));
    check("reset overflow", overflow === 1'b0, $sformatf("got %b want 0", overflow));
    RESET_N = 1'b1;
    @(negedge CLK);

    push(1'b0, {S1, S2, S3, S4}, 4'b1111, 4'b1111);
    load_val(14'd1234);
    wait_idle("1234");
    check("busy run 1234", last_run == 15, $sformatf("got %0d want 15", last_run));

    push(1'b1, {4{SDASH}}, 4'b1111, 4'b1111);
    load_val(14'd10000);
    wait_idle("10000");
    push(1'b0, {4{S9}}, 4'b1111, 4'b1111);
    load_val(14'd9999);
    wait_idle("9999");

    blank_lz = 1'b1;
    push(1'b0, {SOFF, SOFF, SOFF, S7}, 4'b0001, 4'b1111);
    load_val(14'd7);
    wait_idle("blank 7");
    push(1'b0, {SOFF, SOFF, SOFF, S0}, 4'b0001, 4'b1111);
    load_val(14'd0);
    wait_idle("blank 0");
    push(1'b1, {4{SDASH}}, 4'b1111, 4'b1111);
    load_val(14'd10000);
    wait_idle("blank 10000");
    blank_lz = 1'b0;

    push(1'b0, {S0, S0, S2, S5}, 4'b1111, 4'b1111);
    push(1'b0, {S0, S0, S4, S2}, 4'b1111, 4'b1111);
    load_val(14'd25);
    load_val(14'd300);
    load_val(14'd42);
    wait_idle("25/300/42");
    check("busy run 25/42", last_run == 30, $sformatf("got %0d want 30", last_run));

    push(1'b0, {S0, S0, S1, S1}, 4'b1111, 4'b1111);
    push(1'b0, {S0, S0, S2, S2}, 4'b1111, 4'b1111);
    load_val(14'd11);
    repeat (14) @(negedge CLK);
    load_val(14'd22);
    wait_idle("11/22");
    check("busy run 11/22", last_run == 30, $sformatf("got %0d want 30", last_run));

    dp_mask = 4'b0100;
    push(1'b0, {S6, S7, S8, S9}, 4'b1111, 4'b1011);
    load_val(14'd6789);
    wait_idle("dp 6789");

    prev = an;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (an === prev && n < 20);
    check("slot sync", n < 20, $sformatf("got an stuck at %b, want a change", an));
    d0 = 0;
    for (int d = 0; d < ND; d++) if (an === ~(4'b0001 << d)) d0 = d;
    enable = 1'b0;
    ok = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge CLK);
      if (an !== 4'b1111 || seg !== SOFF || dp !== 1'b1) ok = 1'b0;
    end
    check("enable=0 dark", ok, $sformatf("got an=%b seg=%b, want 1111/1111111", an, seg));
    enable = 1'b1;
    for (int i = 21; i <= 28; i++) begin
      @(negedge CLK);
      want = ~(4'b0001 << ((d0 + i / 4) % 4));
      check($sformatf("resume an s%0d", i), an === want, $sformatf("got %b want %b", an, want));
    end
    dp_mask = 4'b0000;

    push(1'b1, {4{SDASH}}, 4'b1111, 4'b1111);
    load_val(14'd10000);
    wait_idle("pre-reset 10000");
    load_val(14'd1234);
    repeat (4) @(negedge CLK);
    #2;
    RESET_N = 1'b0;
    #1;
    check("abort an", an === 4'b1111, $sformatf("got %b want 1111", an));
    check("abort seg", seg === SOFF, $sformatf("got %b want 1111111", seg));
    check("abort dp", dp === 1'b1, $sformatf("got %b want 1", dp));
    check("abort busy", busy === 1'b0, $sformatf("got %b want 0", busy));
    check("abort overflow", overflow === 1'b0, $sformatf("got %b want 0", overflow));
    repeat (2) @(negedge CLK);
    RESET_N = 1'b1;
    @(negedge CLK);
    check("post-reset digit0", an === 4'b1110 && seg === S0,
          $sformatf("got an=%b seg=%b, want 1110/%b", an, seg, S0));
    push(1'b0, {S5, S6, S7, S8}, 4'b1111, 4'b1111);
    load_val(14'd5678);
    wait_idle("5678");
    check("busy run 5678", last_run == 15, $sformatf("got %0d want 15", last_run));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
